// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero short-cut and sign fix-up after the magnitude loop.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] b_mag;
    logic             neg_q;
    logic             neg_r;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    // Operand sign detection and magnitude conversion at capture time
    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dsr_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (-dividend) : dividend;
        dsr_mag = dsr_neg ? (-divisor) : divisor;
    end

    // One restoring step: shift in next dividend bit, trial-subtract divisor magnitude
    always_comb begin
        shifted = {rem, acc[WIDTH-1]};
        trial   = shifted - {1'b0, b_mag};
        q_bit   = ~trial[WIDTH];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
        end
    end

    // Datapath: operand capture, iterative divide, sign fix-up, result hold
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count       <= '0;
            acc         <= '0;
            rem         <= '0;
            b_mag       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc   <= dvd_mag;
                            b_mag <= dsr_mag;
                            rem   <= '0;
                            count <= CW'(WIDTH - 1);
                            neg_q <= dvd_neg ^ dsr_neg;
                            neg_r <= dvd_neg;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc   <= {acc[WIDTH-2:0], q_bit};
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient  <= neg_q ? (-acc) : acc;
                    remainder <= neg_r ? (-rem) : rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             n_rst;
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic division (truncating toward zero when signed)
    function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (!s) begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // Issue one division; optionally pulse a second start or a reset at edge E<n> after E0
    task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, input int rst_at);
        logic [31:0] eq;
        logic [31:0] er;
        bit          edz;
        int          cyc;
        int          lat;
        int          spurious;
        model(s, a, b, eq, er, edz);
        lat = edz ? 0 : WIDTH + 1;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; signed_op = 1'($urandom_range(0, 1)); dividend = $urandom; divisor = $urandom;
        chk({tag, "/busy_e0"}, 32'(busy), 32'd1);
        if (!edz) begin
            chk({tag, "/q_hold_e0"}, quotient, last_q);
            chk({tag, "/r_hold_e0"}, remainder, last_r);
            chk({tag, "/dz_clr_e0"}, 32'(div_by_zero), 32'd0);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc + 1 == pulse_at) begin
                start = 1'b1; signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3;
            end
            if (cyc + 1 == rst_at) n_rst = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == rst_at) begin
                chk({tag, "/rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "/rst_done"}, 32'(done), 32'd0);
                chk({tag, "/rst_q"}, quotient, 32'd0);
                chk({tag, "/rst_r"}, remainder, 32'd0);
                chk({tag, "/rst_dz"}, 32'(div_by_zero), 32'd0);
                n_rst = 1'b1;
                last_q = '0;
                last_r = '0;
                spurious = 0;
                repeat (WIDTH + 8) begin
                    @(posedge clk); #1;
                    if (done !== 1'b0 || busy !== 1'b0) spurious++;
                end
                chk({tag, "/no_done_after_rst"}, 32'(spurious), 32'd0);
                return;
            end
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(lat));
        chk({tag, "/quotient"}, quotient, eq);
        chk({tag, "/remainder"}, remainder, er);
        chk({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "/busy_done"}, 32'(busy), 32'd1);
        last_q = eq;
        last_r = er;
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 32'(done), 32'd0);
        chk({tag, "/busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "/q_hold"}, quotient, eq);
        chk({tag, "/r_hold"}, remainder, er);
        chk({tag, "/dz_hold"}, 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_rst = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/q", quotient, 32'd0);
        chk("reset/r", remainder, 32'd0);
        chk("reset/dz", 32'(div_by_zero), 32'd0);

        // Reset and start together: reset wins
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_vs_start/busy", 32'(busy), 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_vs_start/idle", 32'(busy), 32'd0);

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 0, 0);
        chk("u100_7/q_const", last_q, 32'd14);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("s-7_2/q_const", last_q, 32'hFFFF_FFFD);
        chk("s-7_2/r_const", last_r, 32'hFFFF_FFFF);
        run_op("u5_0", 1'b0, 32'd5, 32'd0, 0, 0);
        run_op("s5_0", 1'b1, 32'd5, 32'd0, 0, 0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op("u_small_big", 1'b0, 32'd3, 32'hFFFF_FFFF, 0, 0);
        run_op("s_neg_zero", 1'b1, 32'hFFFF_FFF9, 32'd0, 0, 0);

        // Start ignored while busy, then reset mid-divide, then a clean operation
        run_op("busy_start", 1'b0, 32'd100, 32'd7, 5, 0);
        chk("busy_start/q_const", last_q, 32'd14);
        run_op("mid_reset", 1'b0, 32'd50, 32'd5, 0, 10);
        run_op("after_reset", 1'b0, 32'd50, 32'd5, 0, 0);
        chk("after_reset/q_const", last_q, 32'd10);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if (i % 6 == 5) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
